vga_framebuffer_arbiter: RTL and testbench



---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_write_holding_reg.sv | 72 +++++++
 rtl/vga_framebuffer_arbiter.sv | 126 ++++++++++++
 tb/tb_vga_framebuffer_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions used by the timing controller and the framebuffer
// arbiter: frame state encoding, default 640x480 timing constants and the
// pixel-coordinate to linear-address helper.
package vga_pkg;

  typedef enum logic {
    S_VBLANK = 1'b0,
    S_ACTIVE = 1'b1
  } frame_state_e;

  // 640x480 @ 60 Hz timing, in pixel clocks / lines.
  localparam int VGA_WIDTH   = 640;
  localparam int VGA_HEIGHT  = 480;
  localparam int H_FRONT     = 16;
  localparam int H_SYNC      = 96;
  localparam int H_BACK      = 48;
  localparam int V_FRONT     = 10;
  localparam int V_SYNC      = 2;
  localparam int V_BACK      = 33;

  // Row-major linear address. Callers truncate to their RAM address width.
  function automatic logic [31:0] xy_to_addr(input logic [31:0] x,
                                             input logic [31:0] y,
                                             input int unsigned w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/vga_write_holding_reg.sv
// One-entry write buffer between the pixel writer and the framebuffer RAM.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   wr_valid_i / wr_ready_o      writer handshake; ready while the entry is empty
//   wr_x_i, wr_y_i, wr_data_i    target pixel and value
//   wr_drop_o                    one-cycle pulse after an out-of-range accept
//   issue_i                      arbiter is writing the held entry this cycle
//   full_o, addr_o, data_o       held entry
module vga_write_holding_reg
  import vga_pkg::*;
#(
  parameter int Width      = VGA_WIDTH,
  parameter int Height     = VGA_HEIGHT,
  parameter int PixelWidth = 8,
  parameter int AddrWidth  = $clog2(Width * Height),
  parameter int XWidth     = $clog2(Width),
  parameter int YWidth     = $clog2(Height)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [XWidth-1:0]     wr_x_i,
  input  logic [YWidth-1:0]     wr_y_i,
  input  logic [PixelWidth-1:0] wr_data_i,
  output logic                  wr_drop_o,
  input  logic                  issue_i,
  output logic                  full_o,
  output logic [AddrWidth-1:0]  addr_o,
  output logic [PixelWidth-1:0] data_o
);

  logic                  full_q;
  logic                  drop_q;
  logic [AddrWidth-1:0]  addr_q;
  logic [PixelWidth-1:0] data_q;
  logic                  accept;
  logic                  in_range;

  assign accept   = wr_valid_i & ~full_q;
  assign in_range = (32'(wr_x_i) < 32'(Width)) && (32'(wr_y_i) < 32'(Height));

  // Accept and issue never coincide: issue needs full_q, accept needs ~full_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      drop_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      drop_q <= 1'b0;
      if (accept) begin
        if (in_range) begin
          full_q <= 1'b1;
          addr_q <= AddrWidth'(xy_to_addr(32'(wr_x_i), 32'(wr_y_i), Width));
          data_q <= wr_data_i;
        end else begin
          drop_q <= 1'b1;
        end
      end else if (issue_i) begin
        full_q <= 1'b0;
      end
    end
  end

  assign wr_ready_o = ~full_q;
  assign wr_drop_o  = drop_q;
  assign full_o     = full_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;

endmodule

// File: rtl/vga_framebuffer_arbiter.sv
// Arbitrates one single-port pixel RAM between VGA scanout (always wins) and
// a single buffered pixel writer that is only serviced in blanking windows.
// Also counts completed frames.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   disp_line/column/v_on/h_on        scanout position from the timing controller
//   wr_valid/ready/x/y/data, wr_drop  pixel writer interface
//   mem_addr/we/wdata, mem_rdata      RAM port (1-cycle read latency)
//   pixel, pixel_valid                scanout pixel, aligned with RAM read data
//   frame_end, frame_count            end-of-frame pulse and wrapping frame counter
module vga_framebuffer_arbiter
  import vga_pkg::*;
#(
  parameter int Width           = VGA_WIDTH,
  parameter int Height          = VGA_HEIGHT,
  parameter int PixelWidth      = 8,
  parameter bit WriteInHBlank   = 1'b1,
  parameter int AddrWidth       = $clog2(Width * Height),
  parameter int XWidth          = $clog2(Width),
  parameter int YWidth          = $clog2(Height),
  parameter int FrameCountWidth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [YWidth-1:0]          disp_line,
  input  logic [XWidth-1:0]          disp_column,
  input  logic                       disp_v_on,
  input  logic                       disp_h_on,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [XWidth-1:0]          wr_x,
  input  logic [YWidth-1:0]          wr_y,
  input  logic [PixelWidth-1:0]      wr_data,
  output logic                       wr_drop,
  output logic [AddrWidth-1:0]       mem_addr,
  output logic                       mem_we,
  output logic [PixelWidth-1:0]      mem_wdata,
  input  logic [PixelWidth-1:0]      mem_rdata,
  output logic [PixelWidth-1:0]      pixel,
  output logic                       pixel_valid,
  output logic                       frame_end,
  output logic [FrameCountWidth-1:0] frame_count
);

  logic                       hr_full;
  logic [AddrWidth-1:0]       hr_addr;
  logic [PixelWidth-1:0]      hr_data;
  logic                       wr_window;
  logic                       issue;
  logic [AddrWidth-1:0]       disp_addr;
  frame_state_e               state_q;
  logic                       frame_end_q;
  logic [FrameCountWidth-1:0] frame_cnt_q;
  logic                       pix_vld_q;

  vga_write_holding_reg #(
    .Width      (Width),
    .Height     (Height),
    .PixelWidth (PixelWidth),
    .AddrWidth  (AddrWidth),
    .XWidth     (XWidth),
    .YWidth     (YWidth)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .wr_x_i     (wr_x),
    .wr_y_i     (wr_y),
    .wr_data_i  (wr_data),
    .wr_drop_o  (wr_drop),
    .issue_i    (issue),
    .full_o     (hr_full),
    .addr_o     (hr_addr),
    .data_o     (hr_data)
  );

  assign wr_window = ~disp_h_on & (~disp_v_on | WriteInHBlank);
  // Gated by rst so a held write is dropped rather than issued during reset.
  assign issue     = hr_full & wr_window & ~rst;
  assign disp_addr = AddrWidth'(xy_to_addr(32'(disp_column), 32'(disp_line), Width));

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = hr_data;
    if (disp_h_on) begin
      mem_addr = disp_addr;
    end else if (issue) begin
      mem_addr = hr_addr;
      mem_we   = 1'b1;
    end
  end

  // Frame tracker: frame ends on the falling edge of the vertical window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_VBLANK;
      frame_end_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      frame_end_q <= 1'b0;
      case (state_q)
        S_VBLANK: if (disp_v_on) state_q <= S_ACTIVE;
        S_ACTIVE: if (!disp_v_on) begin
          state_q     <= S_VBLANK;
          frame_end_q <= 1'b1;
          frame_cnt_q <= frame_cnt_q + 1'b1;
        end
        default:  state_q <= S_VBLANK;
      endcase
    end
  end

  // RAM data arrives one cycle after the address, so delay the qualifier to match.
  always_ff @(posedge clk) begin
    if (rst) pix_vld_q <= 1'b0;
    else     pix_vld_q <= disp_h_on;
  end

  assign pixel_valid = pix_vld_q;
  assign pixel       = pix_vld_q ? mem_rdata : '0;
  assign frame_end   = frame_end_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_framebuffer_arbiter.sv
module tb_vga_framebuffer_arbiter;
  localparam int W = 640, H = 480, PW = 8, XW = 10, YW = 9, AW = 19;

  logic clk, rst;
  logic [YW-1:0] line;
  logic [XW-1:0] col;
  logic vo, ho;

  // Main DUT: writes allowed in h-blank, 16-bit frame counter.
  logic wv, wrdy, wdrop, we, pv, fe;
  logic [XW-1:0] wx;
  logic [YW-1:0] wy;
  logic [PW-1:0] wd, wdata, rdata, pix;
  logic [AW-1:0] addr;
  logic [15:0]   fc;

  // Second DUT: v-blank-only writes, 2-bit frame counter.
  logic wv2, wrdy2, wdrop2, we2, pv2, fe2;
  logic [XW-1:0] wx2;
  logic [YW-1:0] wy2;
  logic [PW-1:0] wd2, wdata2, pix2;
  logic [PW-1:0] rdata2;
  logic [AW-1:0] addr2;
  logic [1:0]    fc2;

  int n_tests = 0, n_fail = 0;
  int fe_cnt = 0, fe_cnt2 = 0;
  logic mon_en = 1'b0;
  logic any_we;
  logic [AW+PW-1:0] q[$];
  logic [AW+PW-1:0] q2[$];
  logic [PW-1:0] ram [0:W*H-1];

  vga_framebuffer_arbiter #(.WriteInHBlank(1'b1)) u_dut (
    .clk(clk), .rst(rst), .disp_line(line), .disp_column(col),
    .disp_v_on(vo), .disp_h_on(ho), .wr_valid(wv), .wr_ready(wrdy),
    .wr_x(wx), .wr_y(wy), .wr_data(wd), .wr_drop(wdrop),
    .mem_addr(addr), .mem_we(we), .mem_wdata(wdata), .mem_rdata(rdata),
    .pixel(pix), .pixel_valid(pv), .frame_end(fe), .frame_count(fc));

  vga_framebuffer_arbiter #(.WriteInHBlank(1'b0), .FrameCountWidth(2)) u_dut2 (
    .clk(clk), .rst(rst), .disp_line(line), .disp_column(col),
    .disp_v_on(vo), .disp_h_on(ho), .wr_valid(wv2), .wr_ready(wrdy2),
    .wr_x(wx2), .wr_y(wy2), .wr_data(wd2), .wr_drop(wdrop2),
    .mem_addr(addr2), .mem_we(we2), .mem_wdata(wdata2), .mem_rdata(rdata2),
    .pixel(pix2), .pixel_valid(pv2), .frame_end(fe2), .frame_count(fc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdata2 = '0;

  // RAM model for the main DUT.
  always @(posedge clk) begin
    if (we === 1'b1) ram[addr] <= wdata;
    rdata <= ram[addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fe === 1'b1)  fe_cnt++;
      if (fe2 === 1'b1) fe_cnt2++;
      if (we !== 1'b0) begin
        chk("we_in_active", 32'(ho), 0);
        if (q.size() == 0) chk("unexpected_we", 32'(we), 0);
        else begin
          logic [AW+PW-1:0] e;
          e = q.pop_front();
          chk("we_addr", 32'(addr), 32'(e[AW+PW-1:PW]));
          chk("we_data", 32'(wdata), 32'(e[PW-1:0]));
        end
      end
      if (we2 !== 1'b0) begin
        chk("we2_in_active", 32'(ho), 0);
        if (q2.size() == 0) chk("unexpected_we2", 32'(we2), 0);
        else begin
          logic [AW+PW-1:0] e;
          e = q2.pop_front();
          chk("we2_addr", 32'(addr2), 32'(e[AW+PW-1:PW]));
          chk("we2_data", 32'(wdata2), 32'(e[PW-1:0]));
        end
      end
    end
  end

  function automatic logic [AW+PW-1:0] ent(input int x, input int y, input logic [PW-1:0] d);
    return {AW'(y * W + x), d};
  endfunction

  initial begin
    // 1: reset with a write request present
    rst = 1'b1; vo = 1'b0; ho = 1'b0; line = '0; col = '0;
    wv = 1'b1; wx = 10'd1; wy = 9'd1; wd = 8'h55;
    wv2 = 1'b1; wx2 = 10'd1; wy2 = 9'd1; wd2 = 8'h55;
    step(); step();
    rst = 1'b0; wv = 1'b0; wv2 = 1'b0; mon_en = 1'b1;
    chk("rst_wr_ready", 32'(wrdy), 1);
    chk("rst_frame_count", 32'(fc), 0);
    chk("rst_pixel_valid", 32'(pv), 0);
    chk("rst_mem_we", 32'(we), 0);
    chk("rst_wr_ready2", 32'(wrdy2), 1);
    chk("rst_frame_count2", 32'(fc2), 0);

    // 2: write in v-blank, then a second back-to-back write
    wv = 1'b1; wx = 10'd5; wy = 9'd2; wd = 8'hA7;
    q.push_back(ent(5, 2, 8'hA7));
    step();
    chk("acc_wr_ready", 32'(wrdy), 0);
    chk("iss_mem_we", 32'(we), 1);
    chk("iss_mem_addr", 32'(addr), 1285);
    chk("iss_mem_wdata", 32'(wdata), 32'h A7);
    wx = 10'd10; wy = 9'd3; wd = 8'h3C;
    q.push_back(ent(10, 3, 8'h3C));
    step();
    chk("iss_wr_ready", 32'(wrdy), 1);
    step();
    wv = 1'b0;
    chk("b2b_mem_we", 32'(we), 1);
    step();
    chk("b2b_wr_ready", 32'(wrdy), 1);

    // 3: scanout read of line 3, column 10
    vo = 1'b1; ho = 1'b1; line = 9'd3; col = 10'd10;
    #1;
    chk("rd_mem_addr", 32'(addr), 1930);
    chk("rd_mem_we", 32'(we), 0);
    step();
    chk("rd_pixel_valid", 32'(pv), 1);
    chk("rd_pixel", 32'(pix), 32'h3C);

    // 4: pending writes held off by active video
    wv = 1'b1; wx = 10'd7; wy = 9'd0; wd = 8'h11; q.push_back(ent(7, 0, 8'h11));
    wv2 = 1'b1; wx2 = 10'd8; wy2 = 9'd0; wd2 = 8'h22; q2.push_back(ent(8, 0, 8'h22));
    step();
    wv = 1'b0; wv2 = 1'b0;
    chk("hold_wr_ready", 32'(wrdy), 0);
    chk("hold_wr_ready2", 32'(wrdy2), 0);
    any_we = 1'b0;
    for (int i = 0; i < 100; i++) begin
      col = 10'(i);
      step();
      any_we = any_we | we | we2;
    end
    chk("active_no_we", 32'(any_we), 0);
    ho = 1'b0;
    #1;
    chk("hblank_we", 32'(we), 1);
    chk("hblank_addr", 32'(addr), 7);
    chk("hblank_we2", 32'(we2), 0);
    step();
    chk("hblank_wr_ready", 32'(wrdy), 1);
    chk("blank_pixel_valid", 32'(pv), 0);
    chk("blank_pixel", 32'(pix), 0);
    step(); step(); step();
    chk("vonly_wr_ready2", 32'(wrdy2), 0);
    vo = 1'b0;
    #1;
    chk("vblank_we2", 32'(we2), 1);
    chk("vblank_addr2", 32'(addr2), 8);
    step();
    chk("f1_frame_end", 32'(fe), 1);
    chk("f1_frame_count", 32'(fc), 1);
    chk("f1_frame_end2", 32'(fe2), 1);
    chk("vblank_wr_ready2", 32'(wrdy2), 1);
    step();
    chk("f1_frame_end_pulse", 32'(fe), 0);

    // 5: out-of-range writes dropped, far-corner write kept
    wv = 1'b1; wx = 10'd640; wy = 9'd0; wd = 8'hFF;
    step();
    wv = 1'b0;
    chk("drop_x_pulse", 32'(wdrop), 1);
    chk("drop_x_ready", 32'(wrdy), 1);
    chk("drop_x_we", 32'(we), 0);
    step();
    chk("drop_x_clear", 32'(wdrop), 0);
    wv = 1'b1; wx = 10'd0; wy = 9'd480;
    step();
    wv = 1'b0;
    chk("drop_y_pulse", 32'(wdrop), 1);
    wv = 1'b1; wx = 10'd639; wy = 9'd479; wd = 8'h5A;
    q.push_back(ent(639, 479, 8'h5A));
    step();
    wv = 1'b0;
    chk("corner_no_drop", 32'(wdrop), 0);
    chk("corner_we", 32'(we), 1);
    step();

    // 6: three more frames; second DUT's 2-bit counter wraps to 0
    for (int f = 0; f < 3; f++) begin
      vo = 1'b1;
      for (int c = 0; c < 6; c++) begin
        ho = (c >= 1 && c <= 3); line = 9'(f); col = 10'(c);
        step();
      end
      vo = 1'b0; ho = 1'b0;
      step();
      chk("frame_end", 32'(fe), 1);
      chk("frame_count", 32'(fc), 32'(2 + f));
      chk("frame_count2", 32'(fc2), 32'((2 + f) % 4));
      step(); step();
    end
    chk("frame_end_pulses", 32'(fe_cnt), 4);
    chk("frame_end_pulses2", 32'(fe_cnt2), 4);

    // Reset while a write is held: it must be discarded
    vo = 1'b1; ho = 1'b1; line = '0; col = '0;
    wv = 1'b1; wx = 10'd1; wy = 9'd1; wd = 8'h77;
    step();
    wv = 1'b0;
    chk("pre_rst_full", 32'(wrdy), 0);
    rst = 1'b1; ho = 1'b0; vo = 1'b0;
    #1;
    chk("in_rst_we", 32'(we), 0);
    step();
    rst = 1'b0;
    chk("post_rst_wr_ready", 32'(wrdy), 1);
    chk("post_rst_frame_count", 32'(fc), 0);
    chk("post_rst_frame_end", 32'(fe), 0);
    step(); step();
    chk("post_rst_we", 32'(we), 0);

    chk("sb_empty", 32'(q.size()), 0);
    chk("sb2_empty", 32'(q2.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
